// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: issues word-aligned bus accesses with byte enables and
// replicated store data, right-aligns load data, stalls the pipeline and flags faults/timeouts.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        MisalignedFault,
  output logic        BusError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [1:0]      off_q, off_d;
  logic            fault_q, fault_d;
  logic            berr_q, berr_d;

  logic       req;
  logic       fault;
  logic [1:0] size;
  logic       limit;

  assign req   = MemRead | MemWrite;
  assign size  = funct3[1:0];
  assign fault = (size == 2'b11) || ((size == 2'b01) && Addr[0]) ||
                 ((size == 2'b10) && (Addr[1:0] != 2'b00));
  assign limit = (cnt_q >= CntLimit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    off_d   = off_q;
    fault_d = 1'b0;
    berr_d  = 1'b0;
    Stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req && fault) begin
          fault_d = 1'b1;
        end else if (req) begin
          Stall   = 1'b1;
          state_d = StReq;
          cnt_d   = '0;
          addr_d  = {Addr[31:2], 2'b00};
          we_d    = MemWrite;
          off_d   = Addr[1:0];
          unique case (size)
            2'b00: begin
              be_d    = 4'b0001 << Addr[1:0];
              wdata_d = {4{WriteData[7:0]}};
            end
            2'b01: begin
              be_d    = 4'b0011 << Addr[1:0];
              wdata_d = {2{WriteData[15:0]}};
            end
            default: begin
              be_d    = 4'b1111;
              wdata_d = WriteData;
            end
          endcase
        end
      end
      StReq: begin
        Stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          state_d = we_q ? StDone : StWait;
        end else if (limit) begin
          state_d = StDone;
          rdata_d = '0;
          berr_d  = 1'b1;
        end
      end
      StWait: begin
        Stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d = StDone;
          rdata_d = mem_rdata >> {off_q, 3'b000};
        end else if (limit) begin
          state_d = StDone;
          rdata_d = '0;
          berr_d  = 1'b1;
        end
      end
      default: begin
        // One un-stalled cycle lets the pipeline advance; requests are not looked at here.
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      fault_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      off_q   <= off_d;
      fault_q <= fault_d;
      berr_q  <= berr_d;
    end
  end

  assign mem_req         = (state_q == StReq);
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_be          = be_q;
  assign mem_wdata       = wdata_q;
  assign ReadData        = rdata_q;
  assign MisalignedFault = fault_q;
  assign BusError        = berr_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed self-checking bench for lsu_bus_ctrl with a short timeout.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WriteData;
  logic [2:0]  funct3;
  logic        Stall;
  logic [31:0] ReadData;
  logic        MisalignedFault, BusError;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .Addr           (Addr),
    .WriteData      (WriteData),
    .funct3         (funct3),
    .Stall          (Stall),
    .ReadData       (ReadData),
    .MisalignedFault(MisalignedFault),
    .BusError       (BusError),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_rd);
    MemRead = 1'b1; Addr = a; funct3 = f3;
    #1 chk("ld_issue_stall", 32'(Stall), 1);
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("ld_req", 32'(mem_req), 1);
    chk("ld_addr", mem_addr, exp_addr);
    chk("ld_be", 32'(mem_be), 32'(exp_be));
    chk("ld_we", 32'(mem_we), 0);
    chk("ld_req_stall", 32'(Stall), 1);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    #1;
    chk("ld_wait_req", 32'(mem_req), 0);
    chk("ld_wait_stall", 32'(Stall), 1);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("ld_done_stall", 32'(Stall), 0);
    chk("ld_done_rdata", ReadData, exp_rd);
    chk("ld_done_berr", 32'(BusError), 0);
    MemRead = 1'b0;
    tick();
    chk("ld_idle_stall", 32'(Stall), 0);
  endtask

  task automatic do_fault(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [2:0] f3);
    MemRead = rd; MemWrite = wr; Addr = a; funct3 = f3;
    #1;
    chk("flt_stall", 32'(Stall), 0);
    chk("flt_req0", 32'(mem_req), 0);
    tick();
    idle_inputs();
    #1;
    chk("flt_pulse", 32'(MisalignedFault), 1);
    chk("flt_req1", 32'(mem_req), 0);
    tick();
    chk("flt_clear", 32'(MisalignedFault), 0);
    chk("flt_req2", 32'(mem_req), 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1; Addr = '0; WriteData = '0; funct3 = 3'b010; mem_rdata = '0;
    tick();
    tick();
    chk("rst_rdata", ReadData, 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_flt", 32'(MisalignedFault), 0);
    chk("rst_berr", 32'(BusError), 0);
    reset = 1'b0;
    tick();

    do_load(32'h100, 3'b010, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
    do_load(32'h203, 3'b100, 32'hAB123456, 32'h200, 4'b1000, 32'h000000AB);
    do_load(32'h202, 3'b001, 32'hAB123456, 32'h200, 4'b1100, 32'h0000AB12);

    // sb with grant arriving on the fourth request cycle
    MemWrite = 1'b1; Addr = 32'h301; WriteData = 32'h000000C5; funct3 = 3'b000;
    #1 chk("sb_issue_stall", 32'(Stall), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_gnt = (i == 3);
      #1;
      chk("sb_req", 32'(mem_req), 1);
      chk("sb_stall", 32'(Stall), 1);
    end
    chk("sb_addr", mem_addr, 32'h300);
    chk("sb_be", 32'(mem_be), 32'h2);
    chk("sb_wdata", mem_wdata, 32'hC5C5C5C5);
    chk("sb_we", 32'(mem_we), 1);
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("sb_done_req", 32'(mem_req), 0);
    chk("sb_done_stall", 32'(Stall), 0);
    chk("sb_rdata_kept", ReadData, 32'h0000AB12);
    MemWrite = 1'b0;
    tick();

    do_fault(1'b1, 1'b0, 32'h102, 3'b010);
    do_fault(1'b0, 1'b1, 32'h101, 3'b001);
    do_fault(1'b1, 1'b0, 32'h100, 3'b011);

    // Timeout: granted load, rvalid never comes; 8 cycles in REQ+WAIT
    MemRead = 1'b1; Addr = 32'h100; funct3 = 3'b010;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 1; i < 8; i++) begin
      #1;
      chk("to_wait_stall", 32'(Stall), 1);
      chk("to_wait_berr", 32'(BusError), 0);
      tick();
    end
    #1;
    chk("to_done_berr", 32'(BusError), 1);
    chk("to_done_rdata", ReadData, 0);
    chk("to_done_stall", 32'(Stall), 0);
    chk("to_done_req", 32'(mem_req), 0);
    MemRead = 1'b0;
    tick();
    chk("to_berr_clear", 32'(BusError), 0);
    chk("to_idle_stall", 32'(Stall), 0);

    do_load(32'h100, 3'b010, 32'h55AA55AA, 32'h100, 4'b1111, 32'h55AA55AA);

    // Reset while in WAIT, then a stale rvalid
    MemRead = 1'b1; Addr = 32'h104; funct3 = 3'b010;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; MemRead = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("rw_rdata", ReadData, 0);
    chk("rw_stall", 32'(Stall), 0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("rw_rvalid_ignored", ReadData, 0);
    chk("rw_req", 32'(mem_req), 0);
    chk("rw_berr", 32'(BusError), 0);
    do_load(32'h100, 3'b010, 32'h0BADF00D, 32'h100, 4'b1111, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store bus controller between the execute/memory pipeline stage and the data-memory bus. It sits directly upstream of the load-extension stage (dmemselect): it issues the word-aligned bus access and generates byte enables and replicated store data. For loads, it right-aligns the returned word by byte offset and presents it as ReadData, ready for funct3-based sign/zero extension. It stalls the pipeline while a bus transaction is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 64, cycles spent in REQ+WAIT before the access is abandoned with BusError (must be >=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
MemRead  input  1  load request from pipeline; held stable while Stall=1
MemWrite  input  1  store request from pipeline; held stable while Stall=1
Addr  input  32  byte address
WriteData  input  32  store data, right-aligned
funct3  input  3  access size/type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use [1:0])
Stall  output  1  freeze pipeline (combinational)
ReadData  output  32  load word shifted right by 8*Addr[1:0]; feeds dmemselect
MisalignedFault  output  1  one-cycle pulse: misaligned or illegal-size access, no bus activity
BusError  output  1  one-cycle pulse: access abandoned on timeout
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  32  {Addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  replicated store data
mem_gnt  input  1  bus accepted request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data word

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE; ReadData=0; timeout counter=0; mem_req, mem_we, mem_be, mem_addr, mem_wdata, MisalignedFault, BusError all 0. Reset mid-transaction abandons it; late mem_gnt/mem_rvalid are ignored in IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: request = MemRead|MemWrite. Both high -> treated as a store.
  - Fault check: funct3[1:0]=11 is illegal; size 01 requires Addr[0]=0; size 10 requires Addr[1:0]=0.
  - On fault: MisalignedFault=1 for the next cycle only. Stall=0, no bus access, stay IDLE.
  - Otherwise: register mem_addr, mem_we, mem_be, mem_wdata and offset; go to REQ. Stall=1 combinationally in this cycle.
- mem_be: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111.
- mem_wdata: byte {4{WriteData[7:0]}}; half {2{WriteData[15:0]}}; word WriteData.
- REQ: mem_req=1; address, be and data held stable until mem_gnt.
  - mem_gnt & store -> DONE.
  - mem_gnt & load -> WAIT.
  - Stall=1.
- WAIT: mem_req=0; Stall=1. On mem_rvalid: ReadData <= mem_rdata >> (8*off), zero-filled; go to DONE. mem_rvalid in the same cycle as mem_gnt (in REQ) is ignored.
- Timeout counter:
  - Clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 without progress: go to DONE, ReadData <= 0, BusError=1 for one cycle (the DONE cycle), mem_req dropped.
  - Progress (gnt/rvalid) in the same cycle as the limit wins over the timeout.
- DONE: Stall=0 for exactly one cycle so the pipeline advances; ReadData is valid. Next state is always IDLE. A new request is not evaluated in DONE.
- ReadData holds its value until the next load completes or times out; stores do not alter it.
- Minimum latency:
  - Store with immediate gnt: 3 cycles (IDLE, REQ, DONE).
  - Load with gnt followed by rvalid on the next cycle: 4 cycles.

Test Plan:
- lw Addr=0x100, gnt on first REQ cycle, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, Stall high for 3 cycles, ReadData=0xDEADBEEF in the DONE cycle.
- lbu Addr=0x203, rdata=0xAB123456 -> mem_addr=0x200, be=1000, ReadData=0x000000AB; lh Addr=0x202 same rdata -> be=1100, ReadData=0x0000AB12.
- sb Addr=0x301 WriteData=0x000000C5, gnt delayed 3 cycles -> mem_req held 4 cycles, be=0010, wdata=0xC5C5C5C5, mem_we=1, ReadData unchanged.
- lw Addr=0x102; sh Addr=0x101; funct3=011 -> MisalignedFault pulses 1 cycle each, mem_req never asserted, Stall=0.
- TIMEOUT_CYCLES=8, load granted but no rvalid -> BusError pulse after 8 cycles in REQ+WAIT, ReadData=0, Stall low in the DONE cycle, then IDLE.
- reset asserted while in WAIT, then rvalid arrives -> state IDLE, ReadData=0, rvalid ignored, next lw completes normally.
